sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/sample_framer_pkg.sv | 7 +
 rtl/framer_skid.sv | 39 +++
 rtl/sample_framer.sv | 62 ++++++
 tb/tb_sample_framer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_framer_pkg.sv
// sample_framer_pkg: shared state encoding and length-width helper for the sample framer.
package sample_framer_pkg;
   typedef enum logic {IDLE, ACTIVE} state_t;
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction
endpackage

// File: rtl/framer_skid.sv
// framer_skid: 2-entry register skid buffer with a registered ready; head entry drives the output.
module framer_skid #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   logic [W-1:0] head, tail;
   logic [1:0] fill, fill_next;
   logic push, pop;
   assign push = in_valid & in_ready;
   assign pop = out_valid & out_ready;
   assign out_valid = fill != 2'd0;
   assign out_data = head;
   assign fill_next = fill + {1'b0, push} - {1'b0, pop};
   // ready is computed from the post-edge fill so it is low exactly when both entries are held
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         head <= '0;
         tail <= '0;
         fill <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         fill <= fill_next;
         in_ready <= fill_next != 2'd2;
         if (push && (fill == 2'd0 || pop))
            head <= in_data;
         else if (pop && fill == 2'd2)
            head <= tail;
         if (push && !pop && fill == 2'd1)
            tail <= in_data;
      end
endmodule

// File: rtl/sample_framer.sv
// sample_framer: cuts an input sample stream into packets of a latched length, closing early on i_tlast.
module sample_framer import sample_framer_pkg::*; #(
   parameter  int WIDTH   = 32,
   parameter  int MAX_LEN = 4096,
   localparam int LEN_W   = len_w(MAX_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LEN_W-1:0] len,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [15:0]      pkt_count,
   output logic             short_pkt,
   output logic             busy
);
   state_t state, state_next;
   logic [LEN_W-1:0] cnt, eff_len, eff, cur;
   logic accept, hit, close;
   assign accept = i_tvalid & i_tready;
   assign busy = state == ACTIVE;
   // in IDLE the length comes straight from len so the first sample uses the fresh value
   always_comb begin
      eff = (state == IDLE) ? ((len == '0 || len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len) : eff_len;
      cur = cnt + LEN_W'(1);
      hit = cur == eff;
      close = accept & (hit | i_tlast);
      state_next = close ? IDLE : (accept ? ACTIVE : state);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         eff_len <= '0;
         short_pkt <= 1'b0;
         pkt_count <= '0;
      end else begin
         state <= state_next;
         if (accept)
            cnt <= close ? '0 : cur;
         if (accept && state == IDLE)
            eff_len <= eff;
         short_pkt <= accept & i_tlast & ~hit;
         if (o_tvalid && o_tready && o_tlast)
            pkt_count <= pkt_count + 16'd1;
      end
   framer_skid #(.W(WIDTH + 1)) u_skid (
      .clk(clk),
      .reset(reset),
      .in_data({hit | i_tlast, i_tdata}),
      .in_valid(i_tvalid),
      .in_ready(i_tready),
      .out_data({o_tlast, o_tdata}),
      .out_valid(o_tvalid),
      .out_ready(o_tready)
   );
endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer: directed checks of framing, early close, length clamping, backpressure and reset.
module tb_sample_framer;
   logic clk, reset;
   logic [3:0] len;
   logic [31:0] i_tdata, o_tdata;
   logic i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;
   logic [15:0] pkt_count;
   logic short_pkt, busy;
   logic alt, tog;
   int errors = 0, checks = 0;
   int occ = 0, rdy_err = 0, rdy_low = 0, stab_err = 0, short_seen = 0;
   bit prev_stall = 0;
   logic [32:0] prev_word;
   logic [32:0] out_q[$], exp_q[$];

   assign o_tready = alt ? tog : 1'b1;

   sample_framer #(.WIDTH(32), .MAX_LEN(8)) dut (
      .clk(clk), .reset(reset), .len(len),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .pkt_count(pkt_count), .short_pkt(short_pkt), .busy(busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      tog = 1;
      forever begin
         @(posedge clk);
         #1;
         if (alt) tog = ~tog;
      end
   end

   // passive monitor: collects output handshakes and tracks occupancy against i_tready
   always @(negedge clk) begin
      if (reset) begin
         occ = 0;
         prev_stall = 0;
      end else begin
         if (i_tready !== (occ != 2)) rdy_err++;
         if (!i_tready) rdy_low++;
         if (prev_stall && (o_tvalid !== 1'b1 || {o_tlast, o_tdata} !== prev_word)) stab_err++;
         if (short_pkt) short_seen++;
         if (o_tvalid && o_tready) out_q.push_back({o_tlast, o_tdata});
         occ = occ + int'(i_tvalid && i_tready) - int'(o_tvalid && o_tready);
         prev_stall = o_tvalid && !o_tready;
         prev_word = {o_tlast, o_tdata};
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic l);
      bit ok;
      ok = 0;
      i_tdata = d;
      i_tlast = l;
      i_tvalid = 1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = i_tready;
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         checks++;
         errors++;
         $error("FAIL push_timeout observed=%0h expected=accepted", d);
      end
      i_tvalid = 0;
      i_tlast = 0;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic check_out(input string tag);
      chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
      out_q.delete();
      exp_q.delete();
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2;
      reset = 0;
      @(posedge clk);
      #1;
      chk("ready_after_reset", 64'(i_tready), 64'd1);
   endtask

   initial begin
      reset = 0;
      len = 4;
      i_tdata = 0;
      i_tlast = 0;
      i_tvalid = 0;
      alt = 0;
      #2 reset = 1;
      repeat (2) @(negedge clk);
      chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
      chk("rst_o_tlast", 64'(o_tlast), 64'd0);
      chk("rst_o_tdata", 64'(o_tdata), 64'd0);
      chk("rst_i_tready", 64'(i_tready), 64'd0);
      chk("rst_short_busy", 64'({short_pkt, busy}), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      release_reset();

      // len=4, ten samples back to back
      push(0, 0);
      chk("first_out_valid", 64'(o_tvalid), 64'd1);
      chk("first_out_data", 64'(o_tdata), 64'd0);
      for (int i = 1; i < 10; i++) push(i, 0);
      chk("t1_busy", 64'(busy), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) expect_word(i, i == 3 || i == 7);
      check_out("t1");
      chk("t1_pkt_count", 64'(pkt_count), 64'd2);

      // reset with a packet open
      reset = 1;
      #1;
      chk("mid_rst_o_tvalid", 64'(o_tvalid), 64'd0);
      chk("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      release_reset();
      for (int i = 100; i < 104; i++) push(i, 0);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 100; i < 104; i++) expect_word(i, i == 103);
      check_out("t40");
      chk("t40_pkt_count", 64'(pkt_count), 64'd1);

      // early close by i_tlast on the 3rd of 5
      len = 5;
      short_seen = 0;
      push(10, 0);
      push(11, 0);
      push(12, 1);
      chk("short_pulse_high", 64'(short_pkt), 64'd1);
      push(13, 0);
      chk("short_pulse_low", 64'(short_pkt), 64'd0);
      for (int i = 14; i < 18; i++) push(i, 0);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 10; i < 18; i++) expect_word(i, i == 12 || i == 17);
      check_out("t37");
      chk("t37_short_count", 64'(short_seen), 64'd1);
      chk("t37_pkt_count", 64'(pkt_count), 64'd3);

      // len=0 and len=9 both clamp to MAX_LEN=8
      len = 0;
      for (int i = 20; i < 28; i++) push(i, 0);
      len = 9;
      for (int i = 30; i < 38; i++) push(i, 0);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 20; i < 28; i++) expect_word(i, i == 27);
      for (int i = 30; i < 38; i++) expect_word(i, i == 37);
      check_out("t36");
      chk("t36_pkt_count", 64'(pkt_count), 64'd5);

      // len change mid-packet only affects later packets
      len = 4;
      push(40, 0);
      push(41, 0);
      len = 2;
      for (int i = 42; i < 48; i++) push(i, 0);
      repeat (4) @(posedge clk);
      #1;
      for (int i = 40; i < 48; i++) expect_word(i, i == 43 || i == 45 || i == 47);
      check_out("t39");
      chk("t39_pkt_count", 64'(pkt_count), 64'd8);

      // alternating downstream ready
      len = 4;
      alt = 1;
      rdy_low = 0;
      for (int i = 50; i < 66; i++) push(i, 0);
      repeat (12) @(posedge clk);
      #1;
      alt = 0;
      for (int i = 50; i < 66; i++) expect_word(i, (i - 49) % 4 == 0);
      check_out("t38");
      chk("t38_pkt_count", 64'(pkt_count), 64'd12);
      chk("t38_stall_seen", 64'(rdy_low > 0), 64'd1);

      // i_tlast coinciding with the length limit is not short
      len = 2;
      short_seen = 0;
      push(70, 0);
      push(71, 1);
      repeat (4) @(posedge clk);
      #1;
      expect_word(70, 0);
      expect_word(71, 1);
      check_out("coincident");
      chk("coincident_short", 64'(short_seen), 64'd0);
      chk("coincident_pkt_count", 64'(pkt_count), 64'd13);

      chk("ready_tracks_fill", 64'(rdy_err), 64'd0);
      chk("stall_stability", 64'(stab_err), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
